stencil_input_streamer: RTL and testbench

Feeds pixels into the pointwise accelerator's input port, hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read.
- Host side: the global buffer pushes 16-bit words with a valid/ready handshake into an internal FIFO.
- Accelerator side: the accelerator pulls one word per cycle by asserting read_en; the streamer answers on the same cycle.
- Also counts pixels per frame, pulses on frame end and flags underflow.

---
 rtl/stencil_stream_pkg.sv | 30 +++
 rtl/stencil_sync_fifo.sv | 60 ++++++
 rtl/stencil_input_streamer.sv | 140 ++++++++++++++
 tb/tb_stencil_input_streamer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stencil_stream_pkg.sv
// ============================================================================
// Module  : stencil_stream_pkg
// Purpose : Shared defaults, FSM state encoding and width helpers for the
//           stencil input streamer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package stencil_stream_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stencil_sync_fifo.sv
// ============================================================================
// Module  : stencil_sync_fifo
// Purpose : Single-clock first-word-fall-through FIFO with occupancy output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stencil_sync_fifo
    import stencil_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int PTR_W = index_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stencil_input_streamer.sv
// ============================================================================
// Module  : stencil_input_streamer
// Purpose : Host-to-accelerator pixel streamer with priming FSM, frame counter
//           and sticky underflow flag. INPUT_STREAMER_CHECKSUM_EN adds a
//           per-frame wrapping checksum of served words.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stencil_input_streamer
    import stencil_stream_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int PRIME_LEVEL  = 8,
    parameter int FRAME_PIXELS = 4096
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    input  logic                            read_en,
    output logic [DATA_W-1:0]               read_data,
    output logic                            primed,
    output logic                            frame_done,
    output logic                            underflow,
    output logic [$clog2(FRAME_PIXELS)-1:0] pixel_count
`ifdef INPUT_STREAMER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]               checksum,
    output logic [DATA_W-1:0]               checksum_last
`endif
);

    localparam int                CNT_W    = count_width(DEPTH);
    localparam int                PIX_W    = $clog2(FRAME_PIXELS);
    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

    state_e            state_q;
    state_e            state_d;
    logic [PIX_W-1:0]  pixel_count_q;
    logic              frame_done_q;
    logic              underflow_q;
    logic [DATA_W-1:0] last_word_q;

    logic [CNT_W-1:0]  w_fifo_count;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_frame_end;

    assign w_empty     = (w_fifo_count == '0);
    assign in_ready    = (w_fifo_count != CNT_W'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_pop       = read_en && !w_empty;
    assign w_frame_end = read_en && (pixel_count_q == LAST_PIX);

    stencil_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (w_push),
        .wdata_i (in_data),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_head),
        .count_o (w_fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_push)                                state_d = ST_PRIME;
            ST_PRIME:  if (w_fifo_count >= CNT_W'(PRIME_LEVEL))   state_d = ST_STREAM;
            ST_STREAM: if (w_frame_end)                           state_d = ST_IDLE;
            default:                                              state_d = ST_IDLE;
        endcase
    end

    // An empty-FIFO read still consumes an accelerator cycle, so the frame
    // counter advances on every read_en, not only on real pops.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q       <= ST_IDLE;
            pixel_count_q <= '0;
            frame_done_q  <= 1'b0;
            underflow_q   <= 1'b0;
            last_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= w_frame_end;
            if (read_en) begin
                pixel_count_q <= w_frame_end ? '0 : pixel_count_q + PIX_W'(1);
            end
            if (read_en && w_empty) begin
                underflow_q <= 1'b1;
            end
            if (w_pop) begin
                last_word_q <= w_fifo_head;
            end
        end
    end

    assign read_data   = w_empty ? last_word_q : w_fifo_head;
    assign primed      = (state_q == ST_STREAM);
    assign frame_done  = frame_done_q;
    assign underflow   = underflow_q;
    assign pixel_count = pixel_count_q;

`ifdef INPUT_STREAMER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] checksum_last_q;
    logic [DATA_W-1:0] w_sum_next;

    assign w_sum_next = checksum_q + (w_pop ? w_fifo_head : '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            checksum_q      <= '0;
            checksum_last_q <= '0;
        end else if (w_frame_end) begin
            checksum_q      <= '0;
            checksum_last_q <= w_sum_next;
        end else begin
            checksum_q      <= w_sum_next;
        end
    end

    assign checksum      = checksum_q;
    assign checksum_last = checksum_last_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stencil_input_streamer.sv
// ============================================================================
// Module  : tb_stencil_input_streamer
// Purpose : Self-checking bench for stencil_input_streamer against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stencil_input_streamer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int PL    = 8;
    localparam int FP    = 4;
    localparam int M_IDLE = 0, M_PRIME = 1, M_STREAM = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          read_en = 1'b0;
    logic          in_ready;
    logic [DW-1:0] read_data;
    logic          primed;
    logic          frame_done;
    logic          underflow;
    logic [1:0]    pixel_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    bit            m_und;
    bit            m_fd;
    int            m_pc;
    int            m_st;

    always #5 clk = ~clk;

    stencil_input_streamer #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .PRIME_LEVEL  (PL),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .read_en     (read_en),
        .read_data   (read_data),
        .primed      (primed),
        .frame_done  (frame_done),
        .underflow   (underflow),
        .pixel_count (pixel_count)
    );

    function automatic logic [DW-1:0] exp_rd();
        return (mq.size() > 0) ? mq[0] : m_last;
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        read_en  = r;
        #1;
    endtask

    // Advance one clock and apply the behavioural rules to the model.
    task automatic step();
        bit push, pop, fe;
        @(posedge clk);
        if (!rst_n || flush) begin
            mq.delete();
            m_last = '0;
            m_und  = 1'b0;
            m_pc   = 0;
            m_fd   = 1'b0;
            m_st   = M_IDLE;
        end else begin
            push = in_valid && (mq.size() != DEPTH);
            pop  = read_en && (mq.size() > 0);
            fe   = read_en && (m_pc == FP - 1);
            case (m_st)
                M_IDLE:   if (push)            m_st = M_PRIME;
                M_PRIME:  if (mq.size() >= PL) m_st = M_STREAM;
                default:  if (fe)              m_st = M_IDLE;
            endcase
            if (read_en && mq.size() == 0) m_und = 1'b1;
            if (pop)  m_last = mq.pop_front();
            if (push) mq.push_back(in_data);
            if (read_en) m_pc = (m_pc + 1) % FP;
            m_fd = fe;
        end
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        drive(0, '0, 0);
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 16'h5A5A, 1);
        repeat (3) step();
        rst_n = 1'b1;
        drive(0, '0, 0);
        checks += 6;
        if (in_ready !== 1'b1)     begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        if (primed !== 1'b0)       begin failures++; $display("FAIL reset_primed got=%0b exp=0", primed); end
        if (read_data !== 16'h0)   begin failures++; $display("FAIL reset_read_data got=%0h exp=0", read_data); end
        if (underflow !== 1'b0)    begin failures++; $display("FAIL reset_underflow got=%0b exp=0", underflow); end
        if (pixel_count !== 2'd0)  begin failures++; $display("FAIL reset_pixel_count got=%0d exp=0", pixel_count); end
        if (frame_done !== 1'b0)   begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
    endtask

    task automatic test_prime_stream();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 16'(i), 0);
            step();
        end
        checks++;
        if (primed !== 1'b0) begin failures++; $display("FAIL prime_early got=%0b exp=0", primed); end
        drive(0, '0, 0);
        step();
        checks++;
        if (primed !== 1'b1) begin failures++; $display("FAIL prime_rise got=%0b exp=1", primed); end
        for (int i = 1; i <= 8; i++) begin
            drive(0, '0, 1);
            checks++;
            if (read_data !== 16'(i)) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, read_data, i); end
            step();
            checks += 2;
            if (pixel_count !== 2'(m_pc)) begin failures++; $display("FAIL stream_pixcnt got=%0d exp=%0d", pixel_count, m_pc); end
            if (primed !== (m_st == M_STREAM)) begin failures++; $display("FAIL stream_primed got=%0b exp=%0b", primed, m_st == M_STREAM); end
        end
        drive(0, '0, 0);
        checks += 2;
        if (read_data !== 16'h0008) begin failures++; $display("FAIL stream_hold got=%0h exp=8", read_data); end
        if (in_ready !== 1'b1)      begin failures++; $display("FAIL stream_empty_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_full();
        logic [DW-1:0] w [16];
        do_flush();
        for (int i = 0; i < 16; i++) begin
            w[i] = DW'($urandom);
            drive(1, w[i], 0);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_early[%0d] got=%0b exp=1", i, in_ready); end
            step();
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", in_ready); end
        drive(1, 16'hDEAD, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(0, '0, 1);
            checks++;
            if (read_data !== w[i]) begin failures++; $display("FAIL full_drain[%0d] got=%0h exp=%0h", i, read_data, w[i]); end
            step();
        end
        drive(0, '0, 0);
        checks += 2;
        if (read_data !== w[15]) begin failures++; $display("FAIL full_hold got=%0h exp=%0h", read_data, w[15]); end
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL full_after_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] word;
        int            pc0;
        do_flush();
        word = DW'($urandom);
        drive(1, word, 0);
        step();
        drive(0, '0, 1);
        step();
        pc0 = m_pc;
        drive(0, '0, 1);
        checks += 2;
        if (underflow !== 1'b0) begin failures++; $display("FAIL under_pre got=%0b exp=0", underflow); end
        if (read_data !== word) begin failures++; $display("FAIL under_hold_pre got=%0h exp=%0h", read_data, word); end
        step();
        drive(0, '0, 0);
        checks += 3;
        if (underflow !== 1'b1) begin failures++; $display("FAIL under_set got=%0b exp=1", underflow); end
        if (read_data !== word) begin failures++; $display("FAIL under_hold got=%0h exp=%0h", read_data, word); end
        if (pixel_count !== 2'((pc0 + 1) % FP)) begin failures++; $display("FAIL under_pixcnt got=%0d exp=%0d", pixel_count, (pc0 + 1) % FP); end
        repeat (3) step();
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL under_sticky got=%0b exp=1", underflow); end
        do_flush();
        checks += 2;
        if (underflow !== 1'b0) begin failures++; $display("FAIL under_flush got=%0b exp=0", underflow); end
        if (read_data !== 16'h0) begin failures++; $display("FAIL under_flush_data got=%0h exp=0", read_data); end
    endtask

    task automatic test_frame_wrap();
        do_flush();
        for (int i = 0; i < 8; i++) begin
            drive(1, 16'h00A0 + 16'(i), 0);
            step();
        end
        drive(0, '0, 0);
        step();
        checks++;
        if (primed !== 1'b1) begin failures++; $display("FAIL frame_primed got=%0b exp=1", primed); end
        for (int i = 0; i < 8; i++) begin
            drive(0, '0, 1);
            checks++;
            if (read_data !== 16'h00A0 + 16'(i)) begin failures++; $display("FAIL frame_data[%0d] got=%0h exp=%0h", i, read_data, 16'h00A0 + 16'(i)); end
            step();
            checks += 2;
            if (frame_done !== (i == 3 || i == 7)) begin failures++; $display("FAIL frame_done[%0d] got=%0b exp=%0b", i, frame_done, i == 3 || i == 7); end
            if (pixel_count !== 2'((i + 1) % FP)) begin failures++; $display("FAIL frame_pixcnt[%0d] got=%0d exp=%0d", i, pixel_count, (i + 1) % FP); end
            if (i == 3) begin
                checks++;
                if (primed !== 1'b0) begin failures++; $display("FAIL frame_idle got=%0b exp=0", primed); end
            end
        end
        drive(0, '0, 0);
        step();
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL frame_done_pulse got=%0b exp=0", frame_done); end
    endtask

    task automatic test_random_stream();
        logic [DW-1:0] d;
        do_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'($urandom), 0);
            step();
        end
        d = mq[0];
        drive(1, DW'($urandom), 1);
        checks++;
        if (read_data !== d) begin failures++; $display("FAIL pushpop_head got=%0h exp=%0h", read_data, d); end
        step();
        for (int c = 0; c < 1000; c++) begin
            rst_n = (c != 500);
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            checks++;
            if (read_data !== exp_rd()) begin failures++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", c, read_data, exp_rd()); end
            step();
            checks += 5;
            if (in_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rand_ready[%0d] got=%0b exp=%0b", c, in_ready, mq.size() != DEPTH); end
            if (primed !== (m_st == M_STREAM))     begin failures++; $display("FAIL rand_primed[%0d] got=%0b exp=%0b", c, primed, m_st == M_STREAM); end
            if (underflow !== m_und)               begin failures++; $display("FAIL rand_under[%0d] got=%0b exp=%0b", c, underflow, m_und); end
            if (frame_done !== m_fd)               begin failures++; $display("FAIL rand_fdone[%0d] got=%0b exp=%0b", c, frame_done, m_fd); end
            if (pixel_count !== 2'(m_pc))          begin failures++; $display("FAIL rand_pixcnt[%0d] got=%0d exp=%0d", c, pixel_count, m_pc); end
            if (c == 500) begin
                rst_n = 1'b1;
                drive(0, '0, 0);
                checks += 2;
                if (in_ready !== 1'b1)   begin failures++; $display("FAIL midreset_ready got=%0b exp=1", in_ready); end
                if (read_data !== 16'h0) begin failures++; $display("FAIL midreset_data got=%0h exp=0", read_data); end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_prime_stream();
        test_full();
        test_underflow();
        test_frame_wrap();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
